fifo_ctrl_dpram: RTL and testbench

Controller that sequences the single-clock true dual-port RAM (true_dpram_sclk) as a synchronous FIFO. Port A is the push/write port; port B is the pop/read port.
The block owns both pointers and tracks occupancy. It drives almost-full/almost-empty flags from thresholds loaded at init, and keeps sticky overflow/underflow error state.
It sits between a transaction-layer producer (e.g. TLP header/data queue) and its consumer.

---
 rtl/fifo_ctrl_dpram_if.sv | 42 ++++
 rtl/fifo_ctrl_dpram.sv | 246 ++++++++++++++++++++++++
 tb/tb_fifo_ctrl_dpram.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_dpram_if.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_dpram_if
//   Producer/consumer side of the dual-port-RAM FIFO controller.
//   Carries the push and pop handshakes plus the occupancy status.
//
//   Signals:
//     push, push_data      producer write request and data
//     pop                  consumer read request
//     pop_data, pop_valid  head entry, valid one cycle after an accepted pop
//     full, empty          occupancy limits
//     almost_full/empty    threshold flags
//     count                occupancy 0..2**ADDRESS_SIZE
//
//   Modports:
//     master  the producer/consumer side (drives push/pop)
//     slave   the controller (drives data and status back)
// ---------------------------------------------------------------------------
interface fifo_ctrl_dpram_if #(
  parameter int LINE_SIZE    = 12,
  parameter int ADDRESS_SIZE = 3
);
  logic                  push;
  logic [LINE_SIZE-1:0]  push_data;
  logic                  pop;
  logic [LINE_SIZE-1:0]  pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDRESS_SIZE:0] count;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/fifo_ctrl_dpram.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_dpram
//   Sequences a single-clock true dual-port RAM as a synchronous FIFO.
//   Port A of the RAM is the push (write) port, port B the pop (read) port.
//   The controller owns both pointers, tracks occupancy, drives almost-full /
//   almost-empty flags from thresholds latched during INIT, and holds sticky
//   overflow/underflow error bits until clr_err.
//
//   Ports:
//     clk, reset_L          clock (rising edge), async active-low reset
//     init                  one-cycle pulse: latch thresholds, clear FIFO
//     af_thr, ae_thr        almost-full (count >= af) / almost-empty (count <= ae)
//     clr_err               clear sticky errors and leave ERROR
//     fifo                  push/pop handshake and status (fifo_ctrl_dpram_if.slave)
//     ram_wr_ptr, ram_wr_e, ram_data_w   RAM port A (write)
//     ram_rd_ptr, ram_rd_e, ram_data_r   RAM port B (always reading, data tied 0)
//     ram_q_r               RAM port B registered read data
//     overflow, underflow   sticky error flags
//     state                 FSM state for debug (INIT=0 IDLE=1 ACTIVE=2 ERROR=3)
//
//   Optional build macro:
//     FIFO_CTRL_PEAK_EN     adds output peak_count, the highest occupancy seen
//                           since reset or init.
// ---------------------------------------------------------------------------
module fifo_ctrl_dpram #(
  parameter int LINE_SIZE    = 12,
  parameter int BLOCK_SIZE   = 8,
  parameter int ADDRESS_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    init,
  input  logic [ADDRESS_SIZE:0]   af_thr,
  input  logic [ADDRESS_SIZE:0]   ae_thr,
  input  logic                    clr_err,
  fifo_ctrl_dpram_if.slave        fifo,
  output logic [ADDRESS_SIZE-1:0] ram_wr_ptr,
  output logic [ADDRESS_SIZE-1:0] ram_rd_ptr,
  output logic                    ram_wr_e,
  output logic                    ram_rd_e,
  output logic [LINE_SIZE-1:0]    ram_data_w,
  output logic [LINE_SIZE-1:0]    ram_data_r,
  input  logic [LINE_SIZE-1:0]    ram_q_r,
  output logic                    overflow,
  output logic                    underflow,
  output logic [2:0]              state
`ifdef FIFO_CTRL_PEAK_EN
  ,
  output logic [ADDRESS_SIZE:0]   peak_count
`endif
);

  typedef logic [ADDRESS_SIZE:0]   cnt_t;
  typedef logic [ADDRESS_SIZE-1:0] ptr_t;

  localparam cnt_t FULL_COUNT = cnt_t'(BLOCK_SIZE);
  localparam cnt_t AF_RESET   = cnt_t'(BLOCK_SIZE - 1);
  localparam cnt_t AE_RESET   = cnt_t'(1);
  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam ptr_t PTR_ONE    = ptr_t'(1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_ERROR  = 3'd3
  } state_t;

  state_t state_q, state_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;
  cnt_t   af_thr_q, af_thr_d;
  cnt_t   ae_thr_q, ae_thr_d;
  logic   overflow_q, overflow_d;
  logic   underflow_q, underflow_d;
  logic   pop_valid_q, pop_valid_d;
  logic   full_q, empty_q, af_q, ae_q;
  logic   full_d, empty_d, af_d, ae_d;
  logic   push_acc, pop_acc, push_err, pop_err;

  // Next-state, pointer and occupancy logic. An init pulse (or sitting in
  // INIT) discards the contents and relatches thresholds. In IDLE/ACTIVE the
  // legal half of a push+pop pair still proceeds even when the other half is
  // an error, so a pop on a full FIFO drains one entry while the push traps.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    af_thr_d    = af_thr_q;
    ae_thr_d    = ae_thr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pop_valid_d = 1'b0;
    push_acc    = 1'b0;
    pop_acc     = 1'b0;
    push_err    = 1'b0;
    pop_err     = 1'b0;

    if (init || state_q == ST_INIT) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      af_thr_d    = af_thr;
      ae_thr_d    = ae_thr;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      state_d     = init ? ST_INIT : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          push_acc = fifo.push & ~full_q;
          pop_acc  = fifo.pop & ~empty_q;
          push_err = fifo.push & full_q;
          pop_err  = fifo.pop & empty_q;

          if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
          if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end

          case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
          endcase

          // The RAM samples the old read pointer at this edge, so its
          // registered output carries the head entry in the next cycle.
          pop_valid_d = pop_acc;

          if (push_err) begin
            overflow_d = 1'b1;
          end
          if (pop_err) begin
            underflow_d = 1'b1;
          end

          if (push_err || pop_err) begin
            state_d = ST_ERROR;
          end else if (count_d == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
          end
        end

        ST_ERROR: begin
          if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            state_d     = (count_q == '0) ? ST_IDLE : ST_ACTIVE;
          end
        end

        default: state_d = ST_INIT;
      endcase
    end
  end

  // Status flags are registered from the next occupancy so they line up
  // with count in the same cycle.
  always_comb begin
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= af_thr_d);
    ae_d    = (count_d <= ae_thr_d);
  end

  // State, pointer, occupancy, threshold and flag registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      af_thr_q    <= AF_RESET;
      ae_thr_q    <= AE_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_valid_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      af_thr_q    <= af_thr_d;
      ae_thr_q    <= ae_thr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pop_valid_q <= pop_valid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
    end
  end

`ifdef FIFO_CTRL_PEAK_EN
  cnt_t peak_q;

  // High-water mark of occupancy, restarted by reset or init.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      peak_q <= '0;
    end else if (init || state_q == ST_INIT) begin
      peak_q <= '0;
    end else if (count_d > peak_q) begin
      peak_q <= count_d;
    end
  end

  assign peak_count = peak_q;
`endif

  // Port A writes only when the push is legal; the write itself is harmless
  // in INIT because the pointers are cleared before any pop can see it.
  assign ram_wr_e   = fifo.push & ~full_q & (state_q != ST_ERROR);
  assign ram_data_w = fifo.push_data;
  assign ram_wr_ptr = wr_ptr_q;

  // Port B is a dedicated read port.
  assign ram_rd_e   = 1'b1;
  assign ram_data_r = '0;
  assign ram_rd_ptr = rd_ptr_q;

  assign fifo.pop_data     = ram_q_r;
  assign fifo.pop_valid    = pop_valid_q;
  assign fifo.full         = full_q;
  assign fifo.empty        = empty_q;
  assign fifo.almost_full  = af_q;
  assign fifo.almost_empty = ae_q;
  assign fifo.count        = count_q;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fifo_ctrl_dpram.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_dpram
//   Self-checking bench for fifo_ctrl_dpram. A behavioural RAM provides the
//   registered port-B read data. The reference model is a data queue plus a
//   few mode bits (initialising / trapped in error / sticky errors).
//   Inputs change on the falling edge; outputs are compared 1 time unit
//   after the rising edge. Build with +define+FIFO_CTRL_PEAK_EN to also
//   check peak_count.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_dpram;
  localparam int LINE_SIZE    = 12;
  localparam int BLOCK_SIZE   = 8;
  localparam int ADDRESS_SIZE = 3;

  logic                    clk = 1'b0;
  logic                    reset_L;
  logic                    init;
  logic                    clr_err;
  logic [ADDRESS_SIZE:0]   af_thr;
  logic [ADDRESS_SIZE:0]   ae_thr;
  logic [ADDRESS_SIZE-1:0] ram_wr_ptr;
  logic [ADDRESS_SIZE-1:0] ram_rd_ptr;
  logic                    ram_wr_e;
  logic                    ram_rd_e;
  logic [LINE_SIZE-1:0]    ram_data_w;
  logic [LINE_SIZE-1:0]    ram_data_r;
  logic [LINE_SIZE-1:0]    ram_q_r;
  logic                    overflow;
  logic                    underflow;
  logic [2:0]              state;
`ifdef FIFO_CTRL_PEAK_EN
  logic [ADDRESS_SIZE:0]   peak_count;
`endif

  fifo_ctrl_dpram_if #(.LINE_SIZE(LINE_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) fifo_bus ();

  always #5 clk = ~clk;

  fifo_ctrl_dpram #(
    .LINE_SIZE   (LINE_SIZE),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .af_thr     (af_thr),
    .ae_thr     (ae_thr),
    .clr_err    (clr_err),
    .fifo       (fifo_bus),
    .ram_wr_ptr (ram_wr_ptr),
    .ram_rd_ptr (ram_rd_ptr),
    .ram_wr_e   (ram_wr_e),
    .ram_rd_e   (ram_rd_e),
    .ram_data_w (ram_data_w),
    .ram_data_r (ram_data_r),
    .ram_q_r    (ram_q_r),
    .overflow   (overflow),
    .underflow  (underflow),
    .state      (state)
`ifdef FIFO_CTRL_PEAK_EN
    ,
    .peak_count (peak_count)
`endif
  );

  // Behavioural single-clock true dual-port RAM with registered port-B read.
  logic [LINE_SIZE-1:0] mem [BLOCK_SIZE];

  always @(posedge clk) begin
    if (ram_wr_e) mem[ram_wr_ptr] <= ram_data_w;
    if (!ram_rd_e) mem[ram_rd_ptr] <= ram_data_r;
    else ram_q_r <= mem[ram_rd_ptr];
  end

  // Reference model state.
  logic [LINE_SIZE-1:0] q [$];
  logic [LINE_SIZE-1:0] m_pd;
  bit m_init, m_err, m_ov, m_un, m_pv;
  int m_af, m_ae, m_wr, m_rd, m_peak;
  int checks = 0;
  int errors = 0;

  task automatic compareVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every registered output against the model.
  task automatic checkOutput();
    int sz;
    int exp_state;
    sz = q.size();
    exp_state = m_init ? 0 : (m_err ? 3 : (sz == 0 ? 1 : 2));
    compareVal("count", fifo_bus.count, sz);
    compareVal("full", fifo_bus.full, (sz == BLOCK_SIZE));
    compareVal("empty", fifo_bus.empty, (sz == 0));
    compareVal("almost_full", fifo_bus.almost_full, (sz >= m_af));
    compareVal("almost_empty", fifo_bus.almost_empty, (sz <= m_ae));
    compareVal("state", state, exp_state);
    compareVal("overflow", overflow, m_ov);
    compareVal("underflow", underflow, m_un);
    compareVal("pop_valid", fifo_bus.pop_valid, m_pv);
    if (m_pv) compareVal("pop_data", fifo_bus.pop_data, m_pd);
    compareVal("ram_wr_ptr", ram_wr_ptr, m_wr % BLOCK_SIZE);
    compareVal("ram_rd_ptr", ram_rd_ptr, m_rd % BLOCK_SIZE);
`ifdef FIFO_CTRL_PEAK_EN
    compareVal("peak_count", peak_count, m_peak);
`endif
  endtask

  // Drive one cycle of inputs, check the combinational RAM controls, advance
  // the model across the clock edge and check the registered outputs.
  task automatic applyStimulus(input logic p, input logic [LINE_SIZE-1:0] d,
                               input logic pp, input logic ini, input logic ce);
    bit was_full;
    @(negedge clk);
    fifo_bus.push      = p;
    fifo_bus.push_data = d;
    fifo_bus.pop       = pp;
    init               = ini;
    clr_err            = ce;
    #1;
    compareVal("ram_wr_e", ram_wr_e, p && (q.size() != BLOCK_SIZE) && !m_err);
    compareVal("ram_data_w", ram_data_w, d);
    compareVal("ram_rd_e", ram_rd_e, 1);
    compareVal("ram_data_r", ram_data_r, 0);
    @(posedge clk);
    if (ini || m_init) begin
      q.delete();
      m_init = ini;
      m_err  = 0;
      m_ov   = 0;
      m_un   = 0;
      m_af   = int'(af_thr);
      m_ae   = int'(ae_thr);
      m_pv   = 0;
      m_wr   = 0;
      m_rd   = 0;
      m_peak = 0;
    end else if (m_err) begin
      m_pv = 0;
      if (ce) begin
        m_ov  = 0;
        m_un  = 0;
        m_err = 0;
      end
    end else begin
      was_full = (q.size() == BLOCK_SIZE);
      m_pv = 0;
      if (pp) begin
        if (q.size() > 0) begin
          m_pd = q.pop_front();
          m_pv = 1;
          m_rd++;
        end else begin
          m_un  = 1;
          m_err = 1;
        end
      end
      if (p) begin
        if (!was_full) begin
          q.push_back(d);
          m_wr++;
        end else begin
          m_ov  = 1;
          m_err = 1;
        end
      end
      if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    checkOutput();
  endtask

  // Assert reset away from the clock edge and check outputs immediately.
  task automatic applyReset();
    @(negedge clk);
    fifo_bus.push = 1'b0;
    fifo_bus.pop  = 1'b0;
    init          = 1'b0;
    clr_err       = 1'b0;
    reset_L       = 1'b0;
    #1;
    q.delete();
    m_init = 1;
    m_err  = 0;
    m_ov   = 0;
    m_un   = 0;
    m_af   = BLOCK_SIZE - 1;
    m_ae   = 1;
    m_pv   = 0;
    m_wr   = 0;
    m_rd   = 0;
    m_peak = 0;
    checkOutput();
    @(negedge clk);
    checkOutput();
    reset_L = 1'b1;
  endtask

  initial begin
    logic                 r_push, r_pop, r_init, r_clr;
    logic [LINE_SIZE-1:0] r_data;

    reset_L            = 1'b1;
    init               = 1'b0;
    clr_err            = 1'b0;
    af_thr             = 4'd6;
    ae_thr             = 4'd1;
    fifo_bus.push      = 1'b0;
    fifo_bus.pop       = 1'b0;
    fifo_bus.push_data = '0;
    #3;

    // Reset, then init with af=6 / ae=1.
    applyReset();
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(0, '0, 0, 0, 0);
    compareVal("idle_after_init", state, 1);

    // Fill with 0xA01..0xA08.
    for (int i = 1; i <= 8; i++) applyStimulus(1, LINE_SIZE'(12'hA00 + i), 0, 0, 0);
    compareVal("full_after_8_pushes", fifo_bus.full, 1);
    compareVal("wr_ptr_wrapped", ram_wr_ptr, 0);

    // Drain; data must come back in order.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, '0, 1, 0, 0);
      compareVal("drain_order", fifo_bus.pop_data, 12'hA00 + i);
    end
    compareVal("empty_after_drain", fifo_bus.empty, 1);

    // Steady state at count 3 with simultaneous push/pop across the wrap.
    for (int i = 1; i <= 3; i++) applyStimulus(1, LINE_SIZE'(12'hB00 + i), 0, 0, 0);
    for (int i = 4; i <= 13; i++) begin
      applyStimulus(1, LINE_SIZE'(12'hB00 + i), 1, 0, 0);
      compareVal("steady_count", fifo_bus.count, 3);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0, 0);

    // Underflow traps in ERROR, push is blocked, clr_err recovers to IDLE.
    applyStimulus(0, '0, 1, 0, 0);
    compareVal("underflow_set", underflow, 1);
    applyStimulus(1, 12'h123, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 1);
    compareVal("idle_after_clr", state, 1);

    // Fill, then push+pop while full -> pop taken, overflow, count 7.
    for (int i = 0; i < 8; i++) applyStimulus(1, LINE_SIZE'($urandom), 0, 0, 0);
    applyStimulus(1, 12'hFFF, 1, 0, 0);
    compareVal("overflow_count", fifo_bus.count, 7);
    compareVal("overflow_set", overflow, 1);
    applyReset();
    applyStimulus(0, '0, 0, 0, 0);

`ifdef FIFO_CTRL_PEAK_EN
    // High-water mark: push 5, pop 3, push 1 -> 5; init clears it.
    for (int i = 0; i < 5; i++) applyStimulus(1, LINE_SIZE'($urandom), 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(1, LINE_SIZE'($urandom), 0, 0, 0);
    compareVal("peak_after_seq", peak_count, 5);
    applyStimulus(0, '0, 0, 1, 0);
    compareVal("peak_after_init", peak_count, 0);
    applyStimulus(0, '0, 0, 0, 0);
`endif

    // Randomised traffic including errors, recoveries and re-inits.
    for (int i = 0; i < 400; i++) begin
      r_init = ($urandom_range(0, 49) == 0);
      if (r_init) begin
        af_thr = (ADDRESS_SIZE+1)'($urandom_range(0, BLOCK_SIZE));
        ae_thr = (ADDRESS_SIZE+1)'($urandom_range(0, BLOCK_SIZE));
      end
      r_push = ($urandom_range(0, 99) < 60);
      r_pop  = ($urandom_range(0, 99) < 50);
      r_clr  = ($urandom_range(0, 99) < 40);
      r_data = LINE_SIZE'($urandom);
      applyStimulus(r_push, r_data, r_pop, r_init, r_clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
